// File: rtl/piano_pkg.sv
// Shared types and helpers for the piano playback path.
// Holds the mode encoding, bus widths and the beat length rule.
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b01,
    AUTO   = 2'b10,
    PAUSE  = 2'b11
  } mode_e;

  localparam int NOTE_W = 8;
  localparam int SONG_W = 2;

  function automatic int beat_len(
    input logic [2:0] speed,
    input int         unit
  );
    return unit * (8 - int'(speed));
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat counter: owns the latched speed and the wrap at each beat.
// Clear loads the current speed so a fresh start uses the live setting.
module beat_timer #(
  parameter  int BEAT_UNIT = 4,
  localparam int CNT_W     = $clog2(8 * BEAT_UNIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [2:0]       speed_i,
  output logic             beat_o,
  output logic [CNT_W-1:0] cnt_o
);
  import piano_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic [2:0]       spd_q, spd_d;

  assign last   = CNT_W'(beat_len(spd_q, BEAT_UNIT) - 1);
  assign beat_o = run_i && (cnt_q == last);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    spd_d = spd_q;
    if (clear_i) begin
      cnt_d = '0;
      spd_d = speed_i;
    end else if (run_i) begin
      if (cnt_q == last) begin
        cnt_d = '0;
        spd_d = speed_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      spd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      spd_q <= spd_d;
    end
  end

endmodule

// File: rtl/play_scheduler.sv
// Mode FSM sharing the tone path between live keys and autoplay.
// Drives song select, player enable, beat tick and the note mux.
module play_scheduler #(
  parameter int BEAT_UNIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       play_btn,
  input  logic       stop_btn,
  input  logic [1:0] song_sel,
  input  logic [2:0] speed,
  input  logic [7:0] song_note,
  input  logic       song_end,
  output logic       counterE,
  output logic [1:0] pro,
  output logic       beat,
  output logic [7:0] note_out,
  output logic [1:0] mode
);
  import piano_pkg::*;

  mode_e              mode_q, mode_d;
  logic               ce_q, ce_d;
  logic [SONG_W-1:0]  pro_q, pro_d;
  logic [NOTE_W-1:0]  note_q, note_d, man;
  logic               clr, restart;

  // Lowest set key bit wins
  assign man = key & (~key + NOTE_W'(1));

  always_comb begin
    mode_d  = mode_q;
    pro_d   = pro_q;
    clr     = 1'b0;
    restart = 1'b0;
    unique case (mode_q)
      IDLE: begin
        if (|key) begin
          mode_d = MANUAL;
        end else if (play_btn) begin
          mode_d = AUTO;
          pro_d  = song_sel;
          clr    = 1'b1;
        end
      end
      MANUAL: begin
        if (!(|key)) mode_d = IDLE;
      end
      AUTO: begin
        if (stop_btn || song_end) begin
          mode_d = IDLE;
          clr    = 1'b1;
        end else if (play_btn) begin
          pro_d   = song_sel;
          clr     = 1'b1;
          restart = 1'b1;
        end else if (|key) begin
          mode_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop_btn) begin
          mode_d = IDLE;
          clr    = 1'b1;
        end else if (!(|key)) begin
          mode_d = AUTO;
        end
      end
      default: mode_d = IDLE;
    endcase

    ce_d = (mode_d == AUTO) && !restart;

    unique case (mode_d)
      MANUAL,
      PAUSE:   note_d = man;
      AUTO:    note_d = song_note;
      default: note_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= IDLE;
      ce_q   <= 1'b0;
      pro_q  <= '0;
      note_q <= '0;
    end else begin
      mode_q <= mode_d;
      ce_q   <= ce_d;
      pro_q  <= pro_d;
      note_q <= note_d;
    end
  end

  beat_timer #(
    .BEAT_UNIT(BEAT_UNIT)
  ) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (mode_q == AUTO),
    .clear_i(clr),
    .speed_i(speed),
    .beat_o (beat),
    .cnt_o  ()
  );

  assign counterE = ce_q;
  assign pro      = pro_q;
  assign note_out = note_q;
  assign mode     = mode_q;

endmodule
